// File: rtl/mult_share_arbiter_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: FSM states, datapath widths
// and the round-robin index helper.
package mult_share_arbiter_pkg;

  localparam int unsigned OP_W   = 32;
  localparam int unsigned PROD_W = 64;

  // Requester index; wide enough for up to four requesters.
  typedef logic [1:0] idx_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  function automatic idx_t wrap_inc(input idx_t idx, input int unsigned n);
    idx_t nxt;
    nxt = ((32'(idx) + 32'd1) >= n) ? 2'd0 : idx + 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/mult_share_arbiter_rr.sv
// Round-robin picker: grants the first eligible requester at or after the pointer,
// wrapping around. Purely combinational.
module rr_arbiter
  import mult_share_arbiter_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] eligible,
  input  idx_t            ptr,
  output logic [NREQ-1:0] grant,
  output idx_t            grant_idx,
  output logic            grant_any
);

  logic [NREQ-1:0] rotated;
  idx_t            offset;
  logic [2:0]      sum;

  // Rotate so bit 0 sits under the pointer, take the lowest set bit, then un-rotate.
  always_comb begin
    rotated   = NREQ'({eligible, eligible} >> ptr);
    offset    = 2'd0;
    grant_any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      offset    = rotated[k] ? idx_t'(k) : offset;
      grant_any = grant_any | rotated[k];
    end
    sum       = {1'b0, ptr} + {1'b0, offset};
    grant_idx = (sum >= 3'(NREQ)) ? 2'(sum - 3'(NREQ)) : sum[1:0];
    for (int k = 0; k < NREQ; k++) begin
      grant[k] = grant_any & (grant_idx == idx_t'(k));
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one iterative multiplier between NREQ requesters: round-robin grant, operand
// capture, one-cycle issue pulse, watchdog-guarded wait and per-requester result buffers.
module mult_share_arbiter
  import mult_share_arbiter_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 40
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*OP_W-1:0]   req_mplier,
  input  logic [NREQ*OP_W-1:0]   req_mcand,
  output logic [NREQ-1:0]        resp_valid,
  input  logic [NREQ-1:0]        resp_ready,
  output logic [NREQ*PROD_W-1:0] resp_product,
  output logic [NREQ-1:0]        resp_err,
  output logic                   mul_in_valid,
  output logic [OP_W-1:0]        mul_mplier,
  output logic [OP_W-1:0]        mul_mcand,
  input  logic [PROD_W-1:0]      mul_product,
  input  logic                   mul_out_valid,
  output logic                   busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t          state;
  state_t          state_next;
  idx_t            ptr;
  idx_t            cur;
  logic [OP_W-1:0] op_mplier;
  logic [OP_W-1:0] op_mcand;
  logic [CNT_W-1:0] wd_cnt;

  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] arb_grant;
  idx_t            arb_idx;
  logic            arb_any;
  logic            accept;
  logic            done_ok;
  logic            done_to;
  logic            finish;
  logic [OP_W-1:0] sel_mplier;
  logic [OP_W-1:0] sel_mcand;

  // A requester still holding an unread result is skipped until it drains.
  assign eligible = req_valid & ~resp_valid;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .eligible (eligible),
    .ptr      (ptr),
    .grant    (arb_grant),
    .grant_idx(arb_idx),
    .grant_any(arb_any)
  );

  assign accept       = (state == ST_IDLE) & arb_any & ~rst;
  assign req_ready    = accept ? arb_grant : '0;
  assign mul_in_valid = (state == ST_ISSUE);
  assign mul_mplier   = op_mplier;
  assign mul_mcand    = op_mcand;
  assign busy         = (state != ST_IDLE);

  // Completion wins over the watchdog when both land on the same cycle.
  assign done_ok = (state == ST_WAIT) & mul_out_valid;
  assign done_to = (state == ST_WAIT) & ~mul_out_valid & (wd_cnt == CNT_W'(TIMEOUT - 1));
  assign finish  = done_ok | done_to;

  // Operand mux for the requester picked by the arbiter.
  always_comb begin
    sel_mplier = '0;
    sel_mcand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_mplier = (arb_idx == idx_t'(i)) ? req_mplier[OP_W*i +: OP_W] : sel_mplier;
      sel_mcand  = (arb_idx == idx_t'(i)) ? req_mcand[OP_W*i +: OP_W]  : sel_mcand;
    end
  end

  // Controller next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  state_next = accept ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT:  state_next = finish ? ST_IDLE : ST_WAIT;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Controller state, captured operands, grant owner, pointer and watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= 2'd0;
      cur       <= 2'd0;
      op_mplier <= '0;
      op_mcand  <= '0;
      wd_cnt    <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        cur       <= arb_idx;
        op_mplier <= sel_mplier;
        op_mcand  <= sel_mcand;
      end
      if (state == ST_ISSUE) begin
        wd_cnt <= '0;
      end else if (state == ST_WAIT) begin
        wd_cnt <= wd_cnt + CNT_W'(1);
      end
      if (finish) begin
        ptr <= wrap_inc(cur, NREQ);
      end
    end
  end

  // Result buffers: drain on handshake, fill on completion or watchdog expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid   <= '0;
      resp_err     <= '0;
      resp_product <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (resp_valid[i] && resp_ready[i]) begin
          resp_valid[i] <= 1'b0;
        end
        if (finish && (cur == idx_t'(i))) begin
          resp_valid[i]                     <= 1'b1;
          resp_err[i]                       <= done_to;
          resp_product[PROD_W*i +: PROD_W]  <= done_to ? '0 : mul_product;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter: transaction-level model with a per-cycle
// compare, a 33-cycle multiplier stub, directed scenarios and a randomized soak.
module tb_mult_share_arbiter;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 40;
  localparam int LAT     = 33;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*32-1:0]   req_mplier;
  logic [NREQ*32-1:0]   req_mcand;
  logic [NREQ-1:0]      resp_valid;
  logic [NREQ-1:0]      resp_ready;
  logic [NREQ*64-1:0]   resp_product;
  logic [NREQ-1:0]      resp_err;
  logic                 mul_in_valid;
  logic [31:0]          mul_mplier;
  logic [31:0]          mul_mcand;
  logic [63:0]          mul_product;
  logic                 mul_out_valid;
  logic                 busy;

  always #5 clk = ~clk;

  mult_share_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_mplier(req_mplier), .req_mcand(req_mcand),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_product(resp_product), .resp_err(resp_err),
    .mul_in_valid(mul_in_valid), .mul_mplier(mul_mplier), .mul_mcand(mul_mcand),
    .mul_product(mul_product), .mul_out_valid(mul_out_valid),
    .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Requester intent and stimulus knobs.
  bit          want[NREQ];
  logic [31:0] wa[NREQ];
  logic [31:0] wb[NREQ];
  int          resp_mode[NREQ];   // 0 random, 1 hold low, 2 always high
  bit          auto_en = 0;
  bit          spur_en = 0;
  bit          stub_dead = 0;

  // Transaction-level model: k = cycles since the accepted request (1 = issue cycle).
  bit          m_busy;
  int          m_k;
  int          m_g;
  int          m_ptr;
  logic [31:0] m_a, m_b;
  bit          m_rv[NREQ];
  bit          m_err[NREQ];
  logic [63:0] m_prod[NREQ];
  int          exp_g;

  // Multiplier stub.
  bit          stub_pend = 0;
  int          stub_cnt  = 0;
  logic [63:0] stub_prod = 64'd0;

  // Event marks taken from the DUT for the literal latency checks.
  int          acc_c[NREQ];
  int          rv_c[NREQ];
  logic [63:0] rv_p[NREQ];
  logic        rv_e[NREQ];
  int          iss_c;
  logic [NREQ-1:0] prev_rv = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_k = 0; m_g = 0; m_ptr = 0; m_a = 32'd0; m_b = 32'd0;
    for (int i = 0; i < NREQ; i++) begin
      m_rv[i] = 0; m_err[i] = 0; m_prod[i] = 64'd0;
    end
  endtask

  task automatic clr_marks();
    for (int i = 0; i < NREQ; i++) begin
      acc_c[i] = -1; rv_c[i] = -1; rv_p[i] = 64'd0; rv_e[i] = 1'b0;
    end
    iss_c = -1;
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic gen_requests();
    if (auto_en) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!want[i] && $urandom_range(0, 2) == 0) begin
          want[i] = 1; wa[i] = rand_op(); wb[i] = rand_op();
        end
      end
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]          = want[i];
      req_mplier[32*i +: 32] = wa[i];
      req_mcand[32*i +: 32]  = wb[i];
      case (resp_mode[i])
        1:       resp_ready[i] = 1'b0;
        2:       resp_ready[i] = 1'b1;
        default: resp_ready[i] = ($urandom_range(0, 3) == 0);
      endcase
    end
    mul_out_valid = 1'b0;
    mul_product   = {$urandom, $urandom};
    if (stub_pend) begin
      stub_cnt--;
      if (stub_cnt == 0) begin
        stub_pend = 0;
        if (!stub_dead) begin
          mul_out_valid = 1'b1;
          mul_product   = stub_prod;
        end
      end
    end else if (spur_en && (!m_busy || m_k == 1) && $urandom_range(0, 7) == 0) begin
      mul_out_valid = 1'b1;
    end
  endtask

  task automatic compare_and_log();
    int exp_ready;
    exp_g = -1;
    if (!m_busy && !rst) begin
      for (int off = 0; off < NREQ; off++) begin
        int j;
        j = (m_ptr + off) % NREQ;
        if (exp_g < 0 && want[j] && !m_rv[j]) exp_g = j;
      end
    end
    exp_ready = (exp_g >= 0) ? (1 << exp_g) : 0;
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("mul_in_valid", 64'(mul_in_valid), 64'(m_busy && m_k == 1));
    chk("mul_mplier", 64'(mul_mplier), 64'(m_a));
    chk("mul_mcand", 64'(mul_mcand), 64'(m_b));
    for (int i = 0; i < NREQ; i++) begin
      chk($sformatf("resp_valid[%0d]", i), 64'(resp_valid[i]), 64'(m_rv[i]));
      chk($sformatf("resp_err[%0d]", i), 64'(resp_err[i]), 64'(m_err[i]));
      chk($sformatf("resp_product[%0d]", i), resp_product[64*i +: 64], m_prod[i]);
      if (req_ready[i]) acc_c[i] = cyc;
      if (resp_valid[i] && !prev_rv[i]) begin
        rv_c[i] = cyc; rv_p[i] = resp_product[64*i +: 64]; rv_e[i] = resp_err[i];
      end
      prev_rv[i] = resp_valid[i];
    end
    if (mul_in_valid) iss_c = cyc;
  endtask

  task automatic model_finish(input bit err, input logic [63:0] prod);
    m_rv[m_g] = 1; m_err[m_g] = err; m_prod[m_g] = prod;
    m_ptr = (m_g + 1) % NREQ;
    m_busy = 0; m_k = 0;
  endtask

  task automatic model_update();
    bit rel[NREQ];
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NREQ; i++) rel[i] = m_rv[i] && resp_ready[i];
    for (int i = 0; i < NREQ; i++) if (rel[i]) m_rv[i] = 0;
    if (!m_busy) begin
      if (exp_g >= 0) begin
        m_busy = 1; m_k = 1; m_g = exp_g;
        m_a = wa[exp_g]; m_b = wb[exp_g]; want[exp_g] = 0;
      end
    end else if (m_k >= 2 && mul_out_valid) begin
      model_finish(0, 64'(m_a) * 64'(m_b));
    end else if (m_k == TIMEOUT + 1) begin
      model_finish(1, 64'd0);
    end else begin
      m_k++;
    end
  endtask

  task automatic stub_update();
    if (rst) begin
      stub_pend = 0;
    end else if (mul_in_valid) begin
      stub_pend = 1; stub_cnt = LAT;
      stub_prod = 64'(mul_mplier) * 64'(mul_mcand);
    end
  endtask

  task automatic cycle();
    gen_requests();
    drive_inputs();
    #1;
    compare_and_log();
    model_update();
    stub_update();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_resp(input int i, input int budget);
    int n = 0;
    while (rv_c[i] < 0 && n < budget) begin
      cycle();
      n++;
    end
    chk($sformatf("wait_resp[%0d] within budget", i), 64'(rv_c[i] >= 0), 64'd1);
  endtask

  task automatic wait_accept(input int i, input int budget);
    int n = 0;
    while (acc_c[i] < 0 && n < budget) begin
      cycle();
      n++;
    end
    chk($sformatf("wait_accept[%0d] within budget", i), 64'(acc_c[i] >= 0), 64'd1);
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    want[i] = 1; wa[i] = a; wb[i] = b;
  endtask

  initial begin
    int r;
    rst = 1'b1;
    req_valid = '0; req_mplier = '0; req_mcand = '0; resp_ready = '0;
    mul_product = 64'd0; mul_out_valid = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      want[i] = 0; wa[i] = 32'd0; wb[i] = 32'd0; resp_mode[i] = 2;
    end
    clr_marks();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    cycle();
    rst = 1'b0;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset resp_valid", 64'(resp_valid), 64'd0);
    chk("reset mul_mplier", 64'(mul_mplier), 64'd0);

    // Single request: 3 x 5 with exact latency.
    clr_marks();
    set_req(0, 32'd3, 32'd5);
    wait_resp(0, 100);
    chk("single issue latency", 64'(iss_c), 64'(acc_c[0] + 1));
    chk("single resp latency", 64'(rv_c[0]), 64'(acc_c[0] + 35));
    chk("single product 3x5", rv_p[0], 64'd15);
    repeat (3) cycle();

    // Contention from pointer 0: req0 first, req1 back-to-back.
    rst = 1'b1; cycle(); rst = 1'b0;
    clr_marks();
    set_req(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    set_req(1, 32'd2, 32'd3);
    wait_resp(1, 200);
    chk("contention back-to-back", 64'(acc_c[1]), 64'(acc_c[0] + 35));
    chk("max product", rv_p[0], 64'hFFFF_FFFE_0000_0001);
    chk("contention product 2x3", rv_p[1], 64'd6);
    repeat (3) cycle();
    clr_marks();
    set_req(0, 32'd9, 32'd2);
    wait_resp(0, 100);
    chk("solo product 9x2", rv_p[0], 64'd18);
    repeat (3) cycle();
    // Pointer now at 1: req1 wins the next tie.
    clr_marks();
    set_req(0, 32'd1, 32'd1);
    set_req(1, 32'd3, 32'd3);
    wait_resp(0, 200);
    chk("rr grants req1 first", 64'(acc_c[0]), 64'(acc_c[1] + 35));
    chk("rr product 3x3", rv_p[1], 64'd9);
    repeat (3) cycle();

    // Unread result blocks its owner; the other requester is served meanwhile.
    resp_mode[0] = 1;
    clr_marks();
    set_req(0, 32'd6, 32'd7);
    wait_resp(0, 100);
    clr_marks();
    set_req(0, 32'd2, 32'd2);
    set_req(1, 32'd5, 32'd5);
    wait_resp(1, 100);
    repeat (40) cycle();
    chk("pending req0 not granted", 64'(acc_c[0] < 0), 64'd1);
    chk("req1 served while req0 pending", rv_p[1], 64'd25);
    chk("held product 6x7", resp_product[63:0], 64'd42);
    resp_mode[0] = 2;
    r = cyc;
    wait_accept(0, 10);
    chk("req0 granted after release", 64'(acc_c[0]), 64'(r + 1));
    wait_resp(0, 100);
    chk("post-release product 2x2", rv_p[0], 64'd4);
    repeat (3) cycle();

    // Watchdog: multiplier never completes.
    stub_dead = 1;
    clr_marks();
    set_req(1, 32'd9, 32'd9);
    wait_resp(1, 100);
    chk("timeout latency", 64'(rv_c[1]), 64'(acc_c[1] + 2 + TIMEOUT));
    chk("timeout err", 64'(rv_e[1]), 64'd1);
    chk("timeout product", rv_p[1], 64'd0);
    chk("timeout back to idle", 64'(busy), 64'd0);
    stub_dead = 0;
    repeat (3) cycle();

    // Reset while waiting on the multiplier.
    clr_marks();
    set_req(0, 32'd11, 32'd13);
    wait_accept(0, 10);
    repeat (10) cycle();
    rst = 1'b1; cycle(); rst = 1'b0;
    chk("rst mid-op busy", 64'(busy), 64'd0);
    chk("rst mid-op resp_valid", 64'(resp_valid), 64'd0);
    clr_marks();
    set_req(0, 32'd7, 32'd9);
    wait_resp(0, 100);
    chk("after rst product 7x9", rv_p[0], 64'd63);
    chk("after rst latency", 64'(rv_c[0]), 64'(acc_c[0] + 35));
    repeat (3) cycle();

    // Spurious completions while idle.
    spur_en = 1;
    clr_marks();
    repeat (40) cycle();
    chk("spurious no resp0", 64'(rv_c[0] < 0), 64'd1);
    chk("spurious no resp1", 64'(rv_c[1] < 0), 64'd1);

    // Randomized soak with occasional reset.
    auto_en = 1;
    resp_mode[0] = 0; resp_mode[1] = 0;
    repeat (4000) begin
      rst = ($urandom_range(0, 699) == 0);
      cycle();
    end
    rst = 1'b0;
    auto_en = 0;
    resp_mode[0] = 2; resp_mode[1] = 2;
    repeat (150) cycle();
    chk("drained idle", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
